// File: rtl/rdma_sq_arb_pkg.sv
// rdma_sq_arb_pkg: shared RDMA command/ACK types and limits for the SQ arbiter.
// Optional feature macro used by this slice: RDMA_SQ_ARB_STATS_EN.
package rdma_sq_arb_pkg;

    // Largest requester count the arbiter is built for.
    localparam int RDMA_ARB_MAX_REQ = 16;
    // Width of the virtual-function id that routes ACKs back to a requester.
    localparam int VFID_BITS = 4;

    // Send-queue command as issued by a vFPGA region.
    typedef struct packed {
        logic [4:0]  opcode;
        logic [23:0] qpn;
        logic [47:0] vaddr;
        logic [31:0] len;
    } rdma_req_t;

    // ACK returned by the RoCE stack; vfid names the issuing requester.
    typedef struct packed {
        logic                 rd;
        logic [VFID_BITS-1:0] vfid;
        logic [23:0]          qpn;
    } rdma_ack_t;

    localparam int RDMA_REQ_BITS = $bits(rdma_req_t);
    localparam int RDMA_ACK_BITS = $bits(rdma_ack_t);

    // Index width for an n-entry table (at least one bit).
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rdma_sq_arb_if.sv
// rdma_sq_arb_if: per-requester SQ streams, merged SQ stream and ACK streams.
// The master modport is the arbiter's view; slave is the surrounding fabric.
interface rdma_sq_arb_if
    import rdma_sq_arb_pkg::*;
#(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]             s_req_valid;
    logic [N_REQ-1:0]             s_req_ready;
    rdma_req_t [N_REQ-1:0]        s_req_data;
    logic                         m_req_valid;
    logic                         m_req_ready;
    rdma_req_t                    m_req_data;
    logic                         s_ack_valid;
    logic                         s_ack_ready;
    rdma_ack_t                    s_ack_data;
    logic [N_REQ-1:0]             m_ack_valid;
    logic [N_REQ-1:0]             m_ack_ready;
    rdma_ack_t                    m_ack_data;

    modport master (
        input  s_req_valid, s_req_data, m_req_ready, s_ack_valid, s_ack_data, m_ack_ready,
        output s_req_ready, m_req_valid, m_req_data, s_ack_ready, m_ack_valid, m_ack_data
    );

    modport slave (
        output s_req_valid, s_req_data, m_req_ready, s_ack_valid, s_ack_data, m_ack_ready,
        input  s_req_ready, m_req_valid, m_req_data, s_ack_ready, m_ack_valid, m_ack_data
    );
endinterface

// File: rtl/rdma_sq_arb_rr.sv
// rdma_rr_arb: generic N-way round-robin picker. Searches from r_rr_ptr,
// wrapping modulo N, and moves the pointer past the winner when i_en is set.
module rdma_rr_arb
    import rdma_sq_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = idx_bits(N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_elig,
    input  logic          i_en,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);
    logic [PW-1:0] r_rr_ptr;
    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_j;
    logic [PW-1:0] w_ptr_nxt;
    logic          w_found;
    int            w_sum;

    // Find the first eligible index at or after the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_idx   = {PW{1'b0}};
        w_j     = {PW{1'b0}};
        w_sum   = 32'sd0;
        for (int k = 0; k < N; k++) begin
            w_sum = int'(r_rr_ptr) + k;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end else begin
                w_sum = w_sum;
            end
            w_j = PW'(w_sum);
            if (!w_found && i_elig[w_j]) begin
                w_found = 1'b1;
                w_idx   = w_j;
            end else begin
                w_found = w_found;
            end
        end
    end

    // One-hot grant vector and the post-grant pointer value.
    always_comb begin
        o_grant = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            o_grant[i] = w_found && (w_idx == PW'(i));
        end
        if (w_idx == PW'(N - 1)) begin
            w_ptr_nxt = {PW{1'b0}};
        end else begin
            w_ptr_nxt = w_idx + PW'(1);
        end
    end

    assign o_idx = w_idx;
    assign o_any = w_found;

    // Advance the round-robin pointer only when the grant is actually taken.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr <= {PW{1'b0}};
        end else if (i_en && w_found) begin
            r_rr_ptr <= w_ptr_nxt;
        end
    end
endmodule

// File: rtl/rdma_sq_arb.sv
// rdma_sq_arb: shares the RoCE SQ command port between N_REQ requesters with
// per-requester credits, and routes returning ACKs back by vfid.
// Optional macro RDMA_SQ_ARB_STATS_EN adds 32-bit per-requester grant counters.
module rdma_sq_arb
    import rdma_sq_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int N_CRED = 16
) (
    input  logic                      nclk,
    input  logic                      nreset,
    rdma_sq_arb_if.master             sq
`ifdef RDMA_SQ_ARB_STATS_EN
    ,
    output logic [N_REQ-1:0][31:0]    stat_grant_cnt
`endif
);
    localparam int CW = $clog2(N_CRED) + 1;
    localparam int PW = idx_bits(N_REQ);

    logic [N_REQ-1:0][CW-1:0] r_cred_cnt;
    logic                     r_req_valid;
    rdma_req_t                r_req_data;
    logic [N_REQ-1:0]         r_ack_vld;
    rdma_ack_t                r_ack_data;

    logic [N_REQ-1:0]         w_elig;
    logic [N_REQ-1:0]         w_grant;
    logic [N_REQ-1:0]         w_inc;
    logic [N_REQ-1:0]         w_ack_dec;
    logic [PW-1:0]            w_idx;
    logic                     w_any;
    logic                     w_take;
    logic                     w_ack_hit;
    logic                     w_ack_rdy;
    logic                     w_ack_acc;

    // Grant only into a free (empty or draining) output register.
    assign w_take    = nreset ? 1'b0 : ((!r_req_valid || sq.m_req_ready) && w_any);
    assign w_inc     = w_take ? w_grant : {N_REQ{1'b0}};
    assign w_ack_hit = {1'b0, sq.s_ack_data.vfid} < (VFID_BITS + 1)'(N_REQ);
    assign w_ack_rdy = nreset ? 1'b0 : (!(|r_ack_vld) || (|(r_ack_vld & sq.m_ack_ready)));
    assign w_ack_acc = sq.s_ack_valid && w_ack_rdy;

    // Eligibility from valid plus remaining credit, and per-requester ACK decode.
    always_comb begin
        w_elig    = {N_REQ{1'b0}};
        w_ack_dec = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            w_elig[i]    = sq.s_req_valid[i] && (r_cred_cnt[i] < CW'(N_CRED));
            w_ack_dec[i] = w_ack_acc && w_ack_hit && (sq.s_ack_data.vfid == VFID_BITS'(i));
        end
    end

    rdma_rr_arb #(.N(N_REQ), .PW(PW)) u_arb (
        .i_clk   (nclk),
        .i_rst   (nreset),
        .i_elig  (w_elig),
        .i_en    (w_take),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign sq.s_req_ready = w_inc;
    assign sq.m_req_valid = r_req_valid;
    assign sq.m_req_data  = r_req_data;
    assign sq.s_ack_ready = w_ack_rdy;
    assign sq.m_ack_valid = r_ack_vld;
    assign sq.m_ack_data  = r_ack_data;

    // One-entry command output register: load on grant, clear when drained.
    always_ff @(posedge nclk) begin
        if (nreset) begin
            r_req_valid <= 1'b0;
            r_req_data  <= rdma_req_t'({RDMA_REQ_BITS{1'b0}});
        end else if (w_take) begin
            r_req_valid <= 1'b1;
            r_req_data  <= sq.s_req_data[w_idx];
        end else if (sq.m_req_ready) begin
            r_req_valid <= 1'b0;
        end
    end

    // One-entry ACK register holding a one-hot valid; out-of-range vfids are dropped.
    always_ff @(posedge nclk) begin
        if (nreset) begin
            r_ack_vld  <= {N_REQ{1'b0}};
            r_ack_data <= rdma_ack_t'({RDMA_ACK_BITS{1'b0}});
        end else if (w_ack_acc && w_ack_hit) begin
            r_ack_vld  <= w_ack_dec;
            r_ack_data <= sq.s_ack_data;
        end else if (|(r_ack_vld & sq.m_ack_ready)) begin
            r_ack_vld  <= {N_REQ{1'b0}};
        end
    end

    // Credit counters: grant adds one, accepted ACK removes one (floored at 0).
    always_ff @(posedge nclk) begin
        if (nreset) begin
            r_cred_cnt <= {(N_REQ * CW){1'b0}};
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_inc[i] && !w_ack_dec[i]) begin
                    r_cred_cnt[i] <= r_cred_cnt[i] + CW'(1);
                end else if (w_ack_dec[i] && !w_inc[i] && (r_cred_cnt[i] != {CW{1'b0}})) begin
                    r_cred_cnt[i] <= r_cred_cnt[i] - CW'(1);
                end
            end
        end
    end

`ifdef RDMA_SQ_ARB_STATS_EN
    logic [N_REQ-1:0][31:0] r_stat_cnt;

    // Free-running grant counters, wrapping at 2^32.
    always_ff @(posedge nclk) begin
        if (nreset) begin
            r_stat_cnt <= {(N_REQ * 32){1'b0}};
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_inc[i]) begin
                    r_stat_cnt[i] <= r_stat_cnt[i] + 32'd1;
                end
            end
        end
    end

    assign stat_grant_cnt = r_stat_cnt;
`endif
endmodule

// File: doc/rdma_sq_arb.md
# rdma_sq_arb

Round-robin arbiter that shares the single RoCE send-queue command port between N_REQ requesters (vFPGA regions) and routes the returning RDMA ACKs back to the requester that issued them. Each requester has a bounded number of outstanding commands, enforced with a per-requester credit counter. The block sits between the per-region SQ streams and the flow-control/RoCE stack input, on the network clock.

## Interface
Parameters:
- N_REQ, 4: number of requesters; 1..16.
- N_CRED, 16: maximum outstanding (granted, un-ACKed) commands per requester; power of two, 2..256.

Ports:
- nclk  in  1  network clock.
- nreset  in  1  reset; synchronous, active-high.
- s_req_valid  in  N_REQ  per-requester command valid.
- s_req_ready  out  N_REQ  per-requester command ready.
- s_req_data  in  N_REQ x RDMA_REQ_BITS  per-requester rdma_req_t.
- m_req_valid  out  1  merged command valid to the RoCE SQ.
- m_req_ready  in  1  merged command ready.
- m_req_data  out  RDMA_REQ_BITS  granted rdma_req_t.
- s_ack_valid  in  1  ACK valid from the stack.
- s_ack_ready  out  1  ACK ready.
- s_ack_data  in  RDMA_ACK_BITS  rdma_ack_t; vfid field selects the destination requester.
- m_ack_valid  out  N_REQ  per-requester ACK valid.
- m_ack_ready  in  N_REQ  per-requester ACK ready.
- m_ack_data  out  RDMA_ACK_BITS  ACK payload, broadcast to all requesters; only the selected valid is high.
- stat_grant_cnt  out  N_REQ x 32  grant counters; present only with RDMA_SQ_ARB_STATS_EN.

## Operation
- Eligibility: requester i is eligible when s_req_valid[i] is high and cred_cnt[i] < N_CRED.
- Arbitration: round-robin. Search starts at rr_ptr and wraps modulo N_REQ. The first eligible requester is granted. After the grant, rr_ptr becomes the granted index + 1, wrapping at N_REQ.
- Grant: occurs only when the output register is free (empty, or being drained this cycle). s_req_ready[g] is high for the granted index only, combinationally, in the same cycle; all other ready bits are 0.
- On a grant, s_req_data[g] is loaded into the output register, the owner index is recorded, and cred_cnt[g] increments.
- Credit counters are log2(N_CRED)+1 bits wide. They never exceed N_CRED and never go below 0.
- ACK routing: idx = s_ack_data.vfid.
  - idx < N_REQ: the ACK is loaded into the ACK register and cred_cnt[idx] decrements when the ACK is accepted into the register.
  - idx >= N_REQ: the ACK is accepted and dropped. No valid is raised and no credit changes.
- ACK for a requester whose cred_cnt is 0: forwarded, but the counter saturates at 0.
- Grant and ACK decrement on the same requester in the same cycle: the counter is unchanged.
- Command payload passes through bit-exact; the arbiter never splits or modifies commands.
- Reset: all counters, rr_ptr and both output registers are cleared. This holds for reset asserted mid-transfer as well; in-flight register contents are discarded.

## Timing
- Reset values: m_req_valid=0, m_req_data=0, m_ack_valid=0, m_ack_data=0, s_req_ready=0, s_ack_ready=0, all cred_cnt=0, rr_ptr=0, stat_grant_cnt=0.
- Command path: one-entry output register. A grant in cycle t gives m_req_valid high in cycle t+1. Data and valid hold stable until m_req_ready.
- Throughput: one command per cycle with back-to-back grants when m_req_ready is held high.
- ACK path: one-entry register. s_ack_ready = !ack_reg_valid || m_ack_ready[owner]. Latency is 1 cycle, throughput 1 per cycle.
- Command and ACK paths are independent; neither blocks the other.
- No combinational path from m_req_ready to m_req_valid, or from s_ack_valid to m_ack_valid.

## Configuration
- RDMA_SQ_ARB_STATS_EN defined: per-requester 32-bit grant counters are built. Each increments on every grant, wraps at 2^32, and is driven on stat_grant_cnt.
- RDMA_SQ_ARB_STATS_EN undefined: counters and port are absent. Functional behaviour is otherwise identical.

## Structure
- lynxTypes package: rdma_req_t, rdma_ack_t, RDMA_REQ_BITS and RDMA_ACK_BITS are used as already defined there. The package gains RDMA_ARB_MAX_REQ = 16.
- Sub-module rdma_rr_arb: a generic N-way round-robin picker with eligibility input, one-hot grant and rr_ptr update, reusable elsewhere. Credit counters and ACK routing live in the top.

## Test plan
- Single requester: requester 0 sends 3 commands, m_req_ready=1 → m_req_valid high on cycles t+1..t+3 with identical data; cred_cnt[0]=3.
- Fairness, N_REQ=4: all requesters valid continuously, m_req_ready=1 → grant order 0,1,2,3,0,1,…; 8 grants yield exactly 2 per requester.
- Credit exhaustion, N_CRED=2: requester 1 sends 3 commands with no ACK → only 2 granted and s_req_ready[1] stays 0. An ACK with vfid=1 → the third command is granted the following cycle.
- ACK routing and drop: an ACK with vfid=2 while m_ack_ready[2]=0 → m_ack_valid[2] is held and s_ack_ready=0 until ready. An ACK with vfid=7 (N_REQ=4) → accepted, no m_ack_valid, no credit change.
- Simultaneous grant and ACK: requester 3 is granted in the same cycle its ACK is accepted, with cred_cnt[3]=1 → cred_cnt[3] remains 1.
- Reset mid-operation: nreset asserted with m_req_valid=1 and cred_cnt[0]=5 → next cycle m_req_valid=0, all credits 0, rr_ptr=0. With the macro, stat_grant_cnt is also 0.
